axi_read_arbiter: RTL

- Shares one AXI read path (AR + R channels) between two masters: M0 (instruction fetch) and M1 (data load).
- Sits between the CPU-side master ports and the slave-side read decoder. That decoder feeds the memory slaves and the default slave.
- Exactly one read burst is outstanding at a time. The grant is locked from AR handshake until the RLAST beat completes.
- Round-robin fairness between masters; the master tag is prepended to the ID; burst length is checked against RLAST.

---
 rtl/axi_arb_pkg.sv | 20 ++
 rtl/axi_read_arbiter_rr_pick2.sv | 15 +
 rtl/axi_read_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// Shared widths, master tags and FSM state encoding for the AXI read arbiter.
package axi_arb_pkg;

    localparam int AXI_ID_BITS   = 4;
    localparam int TAG_BITS      = 4;
    localparam int AXI_IDS_BITS  = AXI_ID_BITS + TAG_BITS;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_LEN_BITS  = 4;

    localparam logic [TAG_BITS-1:0] TAG_M0 = 4'd0;
    localparam logic [TAG_BITS-1:0] TAG_M1 = 4'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/axi_read_arbiter_rr_pick2.sv
// Two-way round-robin picker: the master that did not win last time wins a tie.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       any
);

    // Tie goes to the master opposite the previous winner.
    always_comb begin
        any = |req;
        gnt = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master AXI read arbiter, one burst outstanding at a time.
//
// state | meaning
// IDLE  | no burst; pick the next master from pending ARVALIDs
// ADDR  | granted master's AR forwarded to the slave side
// DATA  | R beats routed to the granted master until RLAST
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ID_BITS   = AXI_ID_BITS,
    parameter int IDS_BITS  = ID_BITS + TAG_BITS,
    parameter int ADDR_BITS = AXI_ADDR_BITS,
    parameter int DATA_BITS = AXI_DATA_BITS,
    parameter int LEN_BITS  = AXI_LEN_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ID_BITS-1:0]   ARID_M0,
    input  logic [ADDR_BITS-1:0] ARADDR_M0,
    input  logic [LEN_BITS-1:0]  ARLEN_M0,
    input  logic [2:0]           ARSIZE_M0,
    input  logic [1:0]           ARBURST_M0,
    input  logic                 ARVALID_M0,
    output logic                 ARREADY_M0,
    output logic [ID_BITS-1:0]   RID_M0,
    output logic [DATA_BITS-1:0] RDATA_M0,
    output logic [1:0]           RRESP_M0,
    output logic                 RLAST_M0,
    output logic                 RVALID_M0,
    input  logic                 RREADY_M0,
    input  logic [ID_BITS-1:0]   ARID_M1,
    input  logic [ADDR_BITS-1:0] ARADDR_M1,
    input  logic [LEN_BITS-1:0]  ARLEN_M1,
    input  logic [2:0]           ARSIZE_M1,
    input  logic [1:0]           ARBURST_M1,
    input  logic                 ARVALID_M1,
    output logic                 ARREADY_M1,
    output logic [ID_BITS-1:0]   RID_M1,
    output logic [DATA_BITS-1:0] RDATA_M1,
    output logic [1:0]           RRESP_M1,
    output logic                 RLAST_M1,
    output logic                 RVALID_M1,
    input  logic                 RREADY_M1,
    output logic [IDS_BITS-1:0]  ARID_S,
    output logic [ADDR_BITS-1:0] ARADDR_S,
    output logic [LEN_BITS-1:0]  ARLEN_S,
    output logic [2:0]           ARSIZE_S,
    output logic [1:0]           ARBURST_S,
    output logic                 ARVALID_S,
    input  logic                 ARREADY_S,
    input  logic [IDS_BITS-1:0]  RID_S,
    input  logic [DATA_BITS-1:0] RDATA_S,
    input  logic [1:0]           RRESP_S,
    input  logic                 RLAST_S,
    input  logic                 RVALID_S,
    output logic                 RREADY_S,
    output logic                 burst_err
);

    arb_state_e          state;
    logic                grant;
    logic                last_grant;
    logic [LEN_BITS-1:0] beat_cnt;
    logic [LEN_BITS-1:0] len_q;
    logic                pick_gnt;
    logic                pick_any;
    logic                ar_hs;
    logic                r_beat;
    logic                unused_rid_tag;

    // The slave echoes the tag in the upper ID bits; routing uses the locked grant instead.
    assign unused_rid_tag = ^RID_S[IDS_BITS-1:ID_BITS];

    rr_pick2 u_pick (
        .req  ({ARVALID_M1, ARVALID_M0}),
        .last (last_grant),
        .gnt  (pick_gnt),
        .any  (pick_any)
    );

    assign ar_hs  = ARVALID_S & ARREADY_S;
    assign r_beat = RVALID_S & RREADY_S;

    // Route AR to the slave in ADDR and R back to the granted master in DATA; everything idles at 0.
    always_comb begin
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        ARID_S     = '0;
        ARADDR_S   = '0;
        ARLEN_S    = '0;
        ARSIZE_S   = '0;
        ARBURST_S  = '0;
        ARVALID_S  = 1'b0;
        RID_M0     = '0;
        RDATA_M0   = '0;
        RRESP_M0   = '0;
        RLAST_M0   = 1'b0;
        RVALID_M0  = 1'b0;
        RID_M1     = '0;
        RDATA_M1   = '0;
        RRESP_M1   = '0;
        RLAST_M1   = 1'b0;
        RVALID_M1  = 1'b0;
        RREADY_S   = 1'b0;
        case (state)
            ADDR: begin
                if (grant) begin
                    ARID_S     = {TAG_M1, ARID_M1};
                    ARADDR_S   = ARADDR_M1;
                    ARLEN_S    = ARLEN_M1;
                    ARSIZE_S   = ARSIZE_M1;
                    ARBURST_S  = ARBURST_M1;
                    ARVALID_S  = ARVALID_M1;
                    ARREADY_M1 = ARREADY_S;
                end else begin
                    ARID_S     = {TAG_M0, ARID_M0};
                    ARADDR_S   = ARADDR_M0;
                    ARLEN_S    = ARLEN_M0;
                    ARSIZE_S   = ARSIZE_M0;
                    ARBURST_S  = ARBURST_M0;
                    ARVALID_S  = ARVALID_M0;
                    ARREADY_M0 = ARREADY_S;
                end
            end
            DATA: begin
                if (grant) begin
                    RID_M1    = RID_S[ID_BITS-1:0];
                    RDATA_M1  = RDATA_S;
                    RRESP_M1  = RRESP_S;
                    RLAST_M1  = RLAST_S;
                    RVALID_M1 = RVALID_S;
                    RREADY_S  = RREADY_M1;
                end else begin
                    RID_M0    = RID_S[ID_BITS-1:0];
                    RDATA_M0  = RDATA_S;
                    RRESP_M0  = RRESP_S;
                    RLAST_M0  = RLAST_S;
                    RVALID_M0 = RVALID_S;
                    RREADY_S  = RREADY_M0;
                end
            end
            default: ;
        endcase
    end

    // Grant lock, beat counting against ARLEN, and sticky burst-length error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            len_q      <= '0;
            burst_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant <= pick_gnt;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        len_q    <= ARLEN_S;
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (r_beat) begin
                        beat_cnt <= beat_cnt + LEN_BITS'(1);
                        if (RLAST_S != (beat_cnt == len_q)) begin
                            burst_err <= 1'b1;
                        end
                        if (RLAST_S) begin
                            last_grant <= grant;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
